// File: rtl/vga_frame_capture.sv
// VGA frame capture: samples a VGA sync/RGB stream on pixel strobes, rebuilds
// pixel coordinates from the sync edges and writes one rectangular window of a
// single frame into block RAM, packed 8 pixels per 96-bit word.
module vga_frame_capture #(
    parameter int H_BACK    = 48,
    parameter int V_BACK    = 31,
    parameter int WIN_X0    = 100,
    parameter int WIN_Y0    = 100,
    parameter int WIN_W     = 160,
    parameter int WIN_H     = 115,
    parameter int BASE_ADDR = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    input  logic        start,
    output logic        wea,
    output logic [14:0] addra,
    output logic [95:0] dina,
    output logic        busy,
    output logic        done,
    output logic        frame_err
);

    localparam int WORDS = WIN_W * WIN_H / 8;
    localparam int WCW   = $clog2(WORDS + 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
    // Window bounds expressed directly in raw counter units, so negative
    // coordinates (counter below the back porch) can never match.
    localparam int unsigned X_LO = H_BACK + WIN_X0;
    localparam int unsigned X_HI = X_LO + WIN_W;
    localparam int unsigned Y_LO = V_BACK + WIN_Y0;
    localparam int unsigned Y_HI = Y_LO + WIN_H;
    localparam logic [14:0] BASE = 15'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_e;

    state_e      state_q, state_d;
    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [2:0]  slot_q, slot_d;
    logic [95:0] word_q, word_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [14:0] addra_q, addra_d;
    logic [95:0] dina_q, dina_d;
    logic        wea_q, wea_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        hs_rise, vs_rise, in_win;
    logic [11:0] pixel;

    // Sync edge detection and coordinate counters; a pixel's coordinate is the
    // counter value as updated on the strobe that samples it.
    always_comb begin
        hs_rise   = pix_en & hsync & ~hs_prev_q;
        vs_rise   = pix_en & vsync & ~vs_prev_q;
        hs_prev_d = pix_en ? hsync : hs_prev_q;
        vs_prev_d = pix_en ? vsync : vs_prev_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pix_en) begin
            if (hs_rise)                h_cnt_d = '0;
            else if (h_cnt_q != 10'h3FF) h_cnt_d = h_cnt_q + 10'd1;
            if (vs_rise)                            v_cnt_d = '0;
            else if (hs_rise && v_cnt_q != 10'h3FF) v_cnt_d = v_cnt_q + 10'd1;
        end
        in_win = pix_en &&
                 32'(h_cnt_d) >= X_LO && 32'(h_cnt_d) < X_HI &&
                 32'(v_cnt_d) >= Y_LO && 32'(v_cnt_d) < Y_HI;
    end

    // Capture control: arm, wait for a fresh frame, pack pixels, emit words.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        word_d  = word_q;
        wcnt_d  = wcnt_q;
        addra_d = addra_q;
        dina_d  = dina_q;
        wea_d   = 1'b0;
        err_d   = err_q;
        pixel   = {red, green, blue};
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WAIT_VS;
                    err_d   = 1'b0;
                    slot_d  = '0;
                    wcnt_d  = '0;
                    addra_d = BASE;
                end
            end
            WAIT_VS: begin
                if (vs_rise) state_d = CAPTURE;
            end
            CAPTURE: begin
                // Address moves on the cycle after each write.
                if (wea_q) begin
                    addra_d = addra_q + 15'd1;
                    wcnt_d  = wcnt_q + WCW'(1);
                end
                if (wea_q && wcnt_q == LAST_WORD) begin
                    state_d = DONE;
                end else if (vs_rise) begin
                    // Frame ended early: drop the partial word and give up.
                    state_d = IDLE;
                    err_d   = 1'b1;
                    slot_d  = '0;
                end else if (in_win) begin
                    for (int s = 0; s < 8; s++)
                        if (slot_q == 3'(s)) word_d[12*s +: 12] = pixel;
                    slot_d = slot_q + 3'd1;
                    if (slot_q == 3'd7) begin
                        wea_d  = 1'b1;
                        dina_d = word_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WAIT_VS) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    // All state and registered outputs; reset kills any write in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            slot_q    <= '0;
            word_q    <= '0;
            wcnt_q    <= '0;
            addra_q   <= BASE;
            dina_q    <= '0;
            wea_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            slot_q    <= slot_d;
            word_q    <= word_d;
            wcnt_q    <= wcnt_d;
            addra_q   <= addra_d;
            dina_q    <= dina_d;
            wea_q     <= wea_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wea       = wea_q;
    assign addra     = addra_q;
    assign dina      = dina_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture using a scaled-down VGA timing so several
// frames fit in a short run: 32 pixels x 16 lines per frame, hsync low at
// columns 26..27, vsync low on line 13, window 16x5 at (3,2).
module tb_vga_frame_capture;

    localparam int HB = 4, VB = 2, WX0 = 3, WY0 = 2, WW = 16, WH = 5, BA = 16;
    localparam int NW = WW * WH / 8;
    localparam int HT = 32, VT = 16, HS_LO = 26, HS_HI = 27, VS_LN = 13;

    logic        clock = 1'b0, reset = 1'b0, start = 1'b0;
    logic        pix_en, hsync, vsync;
    logic [3:0]  red, green, blue;
    logic        wea, busy, done, frame_err;
    logic [14:0] addra;
    logic [95:0] dina;

    // Table-driven / idle drive versus the video generator.
    bit          gen_on = 1'b0;
    logic        t_pe = 1'b0, t_hs = 1'b1, t_vs = 1'b1;
    logic [11:0] t_pix = '0;
    logic        g_pe = 1'b0, g_hs = 1'b1, g_vs = 1'b1;
    logic [11:0] g_pix = '0;

    assign pix_en = gen_on ? g_pe : t_pe;
    assign hsync  = gen_on ? g_hs : t_hs;
    assign vsync  = gen_on ? g_vs : t_vs;
    assign red    = gen_on ? g_pix[11:8] : t_pix[11:8];
    assign green  = gen_on ? g_pix[7:4]  : t_pix[7:4];
    assign blue   = gen_on ? g_pix[3:0]  : t_pix[3:0];

    vga_frame_capture #(
        .H_BACK(HB), .V_BACK(VB), .WIN_X0(WX0), .WIN_Y0(WY0),
        .WIN_W(WW), .WIN_H(WH), .BASE_ADDR(BA)
    ) dut (
        .clock(clock), .reset(reset), .pix_en(pix_en), .hsync(hsync),
        .vsync(vsync), .red(red), .green(green), .blue(blue), .start(start),
        .wea(wea), .addra(addra), .dina(dina), .busy(busy), .done(done),
        .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference image: per-frame random pictures, or a mostly-black frame.
    logic [11:0] img [4][VT][HT];
    bit          zero_mode = 1'b0;
    int          short_f   = -1;

    function automatic logic [11:0] pix_fn(input int f, input int hc, input int vc);
        if (zero_mode) begin
            if (vc == WY0 && hc == WX0)     return 12'h123;
            if (vc == WY0 && hc == WX0 + 1) return 12'h456;
            return 12'h000;
        end
        return img[f % 4][vc][hc];
    endfunction

    // Expected word k of a captured frame: window pixels in raster order.
    function automatic logic [95:0] exp_word(input int f, input int k);
        logic [95:0] w = '0;
        for (int s = 0; s < 8; s++) begin
            int p;
            p = 8 * k + s;
            w[12*s +: 12] = pix_fn(f, WX0 + p % WW, WY0 + p / WW);
        end
        return w;
    endfunction

    // Video generator: random strobe spacing of 1..4 clocks. In frame short_f
    // the vsync pulse is moved into the blanking of line 3, then line 14 follows.
    int p_hc = 0, p_vc = 0, p_f = 0;
    initial begin
        int n_hc = 0, n_vc = 0, n_f = 0, gap = 0;
        forever begin
            @(negedge clock);
            if (gap > 0) begin
                g_pe = 1'b0;
                gap--;
            end else begin
                g_pe  = 1'b1;
                p_hc  = n_hc; p_vc = n_vc; p_f = n_f;
                g_hs  = !(n_hc >= HS_LO && n_hc <= HS_HI);
                g_vs  = !(n_vc == VS_LN || (n_f == short_f && n_vc == 3 && n_hc >= 24));
                g_pix = pix_fn(n_f, n_hc, n_vc);
                n_hc++;
                if (n_hc == HT) begin
                    n_hc = 0;
                    if (n_f == short_f && n_vc == 3) n_vc = 14;
                    else                             n_vc++;
                    if (n_vc == VT) begin
                        n_vc = 0;
                        n_f++;
                    end
                end
                gap = $urandom_range(0, 3);
            end
        end
    end

    // Write monitor.
    logic [14:0] obs_a[$];
    logic [95:0] obs_d[$];
    logic        wea_prev = 1'b0;
    int          dbl = 0;
    always @(negedge clock) begin
        if (wea === 1'b1) begin
            obs_a.push_back(addra);
            obs_d.push_back(dina);
            if (wea_prev) dbl <= dbl + 1;
        end
        wea_prev <= wea;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_until(input int f, input int vc, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 8000 && !ok; i++) begin
            @(negedge clock);
            if ((f < 0 || p_f == f) && p_vc == vc) ok = 1'b1;
        end
        chk({nm, "_reached"}, 96'(ok), 96'(1));
    endtask

    task automatic check_cap(input string nm, input int base, input int f, input int n);
        chk({nm, "_count"}, 96'(obs_a.size() - base), 96'(n));
        for (int k = 0; k < n && base + k < obs_a.size(); k++) begin
            chk($sformatf("%s_addr%0d", nm, k), 96'(obs_a[base+k]), 96'(BA + k));
            chk($sformatf("%s_data%0d", nm, k), obs_d[base+k], exp_word(f, k));
        end
    endtask

    typedef struct packed {
        logic st, pe, hs, vs;
        logic busy, done, err;
    } vec_t;
    vec_t vecs[12];

    initial begin
        int base, fs, fs6, n6, cnt6;
        bit ok;
        vecs[0]  = 7'b0111_000;
        vecs[1]  = 7'b0100_000;
        vecs[2]  = 7'b0111_000;   // vsync rise while idle: ignored
        vecs[3]  = 7'b1000_100;   // arm
        vecs[4]  = 7'b0111_100;   // vsync still high: no edge
        vecs[5]  = 7'b0110_100;
        vecs[6]  = 7'b0001_100;   // no strobe: not sampled
        vecs[7]  = 7'b0111_100;   // rise: enter capture
        vecs[8]  = 7'b1000_100;   // start ignored while busy
        vecs[9]  = 7'b0110_100;
        vecs[10] = 7'b0111_001;   // vsync before any word: abort
        vecs[11] = 7'b1000_100;   // re-arm clears error
        for (int f = 0; f < 4; f++)
            for (int v = 0; v < VT; v++)
                for (int h = 0; h < HT; h++)
                    img[f][v][h] = 12'($urandom);

        // Reset state.
        repeat (3) @(negedge clock);
        chk("rst_wea", 96'(wea), 96'(0));
        chk("rst_addra", 96'(addra), 96'(BA));
        chk("rst_dina", dina, 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_err", 96'(frame_err), 96'(0));
        reset = 1'b1;

        // Random idle traffic without start.
        base = obs_a.size();
        repeat (1000) begin
            @(negedge clock);
            t_pe = 1'($urandom); t_hs = 1'($urandom); t_vs = 1'($urandom);
            t_pix = 12'($urandom);
        end
        @(negedge clock);
        chk("idle_writes", 96'(obs_a.size() - base), 96'(0));
        chk("idle_busy", 96'(busy), 96'(0));
        chk("idle_done", 96'(done), 96'(0));
        chk("idle_addra", 96'(addra), 96'(BA));

        // Control vectors.
        for (int i = 0; i < 12; i++) begin
            start = vecs[i].st; t_pe = vecs[i].pe; t_hs = vecs[i].hs; t_vs = vecs[i].vs;
            @(negedge clock);
            chk($sformatf("vec%0d_busy", i), 96'(busy), 96'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), 96'(done), 96'(vecs[i].done));
            chk($sformatf("vec%0d_err", i), 96'(frame_err), 96'(vecs[i].err));
            chk($sformatf("vec%0d_wea", i), 96'(wea), 96'(0));
            chk($sformatf("vec%0d_addra", i), 96'(addra), 96'(BA));
        end
        start = 1'b0; t_pe = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        gen_on = 1'b1;

        // Full capture of random frame; extra start mid-capture is ignored.
        wait_until(-1, 0, "t2_sync");
        wait_until(-1, 8, "t2_line8");
        fs = p_f; base = obs_a.size();
        pulse_start();
        chk("t2_busy_armed", 96'(busy), 96'(1));
        ok = 1'b0;
        for (int i = 0; i < 8000 && !ok; i++) begin
            @(negedge clock);
            if (obs_a.size() - base >= 3) ok = 1'b1;
        end
        chk("t2_three_writes", 96'(ok), 96'(1));
        pulse_start();
        wait_until(fs + 2, 8, "t2_end");
        check_cap("t2", base, fs + 1, NW);
        chk("t2_done", 96'(done), 96'(1));
        chk("t2_busy", 96'(busy), 96'(0));
        chk("t2_err", 96'(frame_err), 96'(0));

        // Known pixels, rearm from DONE.
        zero_mode = 1'b1;
        wait_until(-1, 8, "t3_line8");
        fs = p_f; base = obs_a.size();
        pulse_start();
        chk("t3_done_cleared", 96'(done), 96'(0));
        chk("t3_busy", 96'(busy), 96'(1));
        wait_until(fs + 2, 8, "t3_end");
        if (obs_a.size() > base) begin
            chk("t3_first_addr", 96'(obs_a[base]), 96'(BA));
            chk("t3_first_data", obs_d[base], 96'h456123);
        end
        check_cap("t3", base, fs + 1, NW);
        zero_mode = 1'b0;

        // Start in the middle of the window rows: wait for the next frame.
        wait_until(-1, 4, "t4_line4");
        fs = p_f; base = obs_a.size();
        pulse_start();
        wait_until(fs, VS_LN, "t4_vsync_line");
        chk("t4_no_early_writes", 96'(obs_a.size() - base), 96'(0));
        wait_until(fs + 2, 8, "t4_end");
        check_cap("t4", base, fs + 1, NW);

        // Early vsync after two window rows.
        wait_until(-1, 8, "t5_line8");
        fs = p_f; base = obs_a.size();
        short_f = fs + 1;
        pulse_start();
        wait_until(fs + 2, 8, "t5_end");
        check_cap("t5", base, fs + 1, 2 * WW / 8);
        chk("t5_err", 96'(frame_err), 96'(1));
        chk("t5_done", 96'(done), 96'(0));
        chk("t5_busy", 96'(busy), 96'(0));
        fs6 = p_f; base = obs_a.size();
        pulse_start();
        chk("t5_err_cleared", 96'(frame_err), 96'(0));
        chk("t5_rearmed", 96'(busy), 96'(1));

        // Reset in the middle of a capture.
        n6 = 0;
        for (int i = 0; i < 8000 && n6 < 5; i++) begin
            @(negedge clock);
            if (wea === 1'b1) n6++;
        end
        chk("t6_five_writes", 96'(n6), 96'(5));
        reset = 1'b0;
        #1;
        chk("t6_wea_drop", 96'(wea), 96'(0));
        chk("t6_addra", 96'(addra), 96'(BA));
        chk("t6_busy", 96'(busy), 96'(0));
        chk("t6_dina", dina, 96'(0));
        cnt6 = obs_a.size();
        for (int k = 0; k < 5 && base + k < cnt6; k++)
            chk($sformatf("t6_data%0d", k), obs_d[base+k], exp_word(fs6 + 1, k));
        @(negedge clock);
        reset = 1'b1;
        wait_until(fs6 + 3, 8, "t6_end");
        chk("t6_no_writes", 96'(obs_a.size() - cnt6), 96'(0));
        chk("t6_busy_after", 96'(busy), 96'(0));
        chk("t6_done_after", 96'(done), 96'(0));
        chk("wea_single_cycle", 96'(dbl), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
